// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, shifts a byte
// with odd parity on device clock falling edges, then checks the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_done,
   output logic       tx_error,
   output logic [1:0] err_code
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_BITS, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    frame_q, frame_d;
   logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
   logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
   logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
   logic          tx_ready_q, tx_ready_d, tx_done_q, tx_done_d, tx_error_q, tx_error_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          fall, timeout_hit, nack_hit, idle_hit;

   assign fall = clk_prev_q & ~clk_sync_q;

   // State register
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         frame_q     <= '0;
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         clk_prev_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         tx_ready_q  <= 1'b0;
         tx_done_q   <= 1'b0;
         tx_error_q  <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_q     <= frame_d;
         clk_meta_q  <= clk_meta_d;
         clk_sync_q  <= clk_sync_d;
         clk_prev_q  <= clk_prev_d;
         data_meta_q <= data_meta_d;
         data_sync_q <= data_sync_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         tx_ready_q  <= tx_ready_d;
         tx_done_q   <= tx_done_d;
         tx_error_q  <= tx_error_d;
         err_code_q  <= err_code_d;
      end
   end

   // Next-state logic
   always_comb begin
      clk_meta_d  = ps2_clk_in;
      clk_sync_d  = clk_meta_q;
      clk_prev_d  = clk_sync_q;
      data_meta_d = ps2_data_in;
      data_sync_d = data_meta_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      frame_d     = frame_q;
      timeout_hit = 1'b0;
      nack_hit    = 1'b0;
      idle_hit    = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            bit_cnt_d = '0;
            if (tx_valid && tx_ready_q) begin
               frame_d = {1'b1, ~^tx_data, tx_data};
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d   = '0;
               state_d = S_RTS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RTS: begin
            cnt_d     = '0;
            bit_cnt_d = '0;
            state_d   = S_BITS;
         end
         S_BITS: begin
            if (fall) begin
               cnt_d     = '0;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'd9) state_d = S_ACK;
            end else if (cnt_q == TO_LAST) begin
               timeout_hit = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ACK: begin
            if (fall) begin
               cnt_d = '0;
               if (!data_sync_q) begin
                  state_d = S_WAIT_IDLE;
               end else begin
                  nack_hit = 1'b1;
                  state_d  = S_IDLE;
               end
            end else if (cnt_q == TO_LAST) begin
               timeout_hit = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (clk_sync_q && data_sync_q) begin
               idle_hit = 1'b1;
               state_d  = S_IDLE;
            end else if (fall) begin
               cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
               timeout_hit = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: registered, derived from the upcoming state
   always_comb begin
      clk_oe_d   = (state_d == S_INHIBIT) || (state_d == S_RTS);
      tx_ready_d = (state_d == S_IDLE);
      tx_done_d  = idle_hit;
      tx_error_d = timeout_hit | nack_hit;
      err_code_d = err_code_q;
      if (timeout_hit) err_code_d = 2'b01;
      else if (nack_hit) err_code_d = 2'b10;
      data_oe_d = 1'b0;
      case (state_d)
         S_RTS: data_oe_d = 1'b1;
         S_BITS: begin
            // Start bit is held from RTS until the first device falling edge
            if (state_q != S_BITS) data_oe_d = 1'b1;
            else if (fall)         data_oe_d = ~frame_q[bit_cnt_q];
            else                   data_oe_d = data_oe_q;
         end
         default: data_oe_d = 1'b0;
      endcase
   end

   assign tx_ready    = tx_ready_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_done     = tx_done_q;
   assign tx_error    = tx_error_q;
   assign err_code    = err_code_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, CLOCK_50 cycles the host holds PS/2 clock low before the request-to-send (100 us).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum CLOCK_50 cycles allowed between device clock falling edges, and in WAIT_IDLE (20 ms).
REQ-003 SHALL have port CLOCK_50  input  1  system clock (50 MHz); all logic on posedge.
REQ-004 SHALL have port resetn  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid  input  1  send request; accepted when tx_valid and tx_ready are both high.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE.
REQ-008 SHALL have port ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous).
REQ-009 SHALL have port ps2_data_in  input  1  raw PS/2 data pin level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = drive PS/2 clock low; 0 = release (open drain).
REQ-011 SHALL have port ps2_data_oe  output  1  1 = drive PS/2 data low; 0 = release.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse: byte sent and ACK received.
REQ-013 SHALL have port tx_error  output  1  one-cycle pulse: transfer aborted.
REQ-014 SHALL have port err_code  output  2  cause of last abort: 01 timeout, 10 no ACK; holds until next error or reset.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_data_in through 2-FF synchronizers; clock falling edge = previous synced 1, current synced 0.
REQ-016 SHALL implement states IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe 0, tx_ready 1; on acceptance latch tx_data, compute odd parity (~^tx_data), clear counters, go INHIBIT.
REQ-018 INHIBIT: clk_oe 1, data_oe 0, for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-019 RTS: data_oe 1 and clk_oe 1 for exactly 1 cycle, then BITS with clk_oe 0 and data_oe held 1 (start bit 0).
REQ-020 BITS: on each device clock falling edge n (n=1..10) SHALL present the next bit on the following cycle: n=1..8 data LSB first, n=9 parity, n=10 stop (data_oe 0); data_oe = inverse of bit value.
REQ-021 After falling edge 10, SHALL go to ACK; on falling edge 11, sampled synced data 0 = ACK ok -> WAIT_IDLE, else set err_code 10, pulse tx_error, go IDLE.
REQ-022 WAIT_IDLE: when synced clock and data are both 1, SHALL pulse tx_done and go IDLE.
REQ-023 Timeout counter SHALL clear on entry to BITS and on every falling edge; if it reaches TIMEOUT_CYCLES in BITS, ACK or WAIT_IDLE: err_code 01, tx_error pulse, both oe 0, IDLE.
REQ-024 tx_done and tx_error SHALL never be high in the same cycle; tx_ready SHALL be 1 in the cycle after either pulse.
REQ-025 tx_valid while tx_ready is 0 SHALL be ignored with no side effects; the latched byte SHALL not change mid-transfer.
REQ-026 Falling edges in IDLE, INHIBIT or RTS (device-initiated traffic) SHALL be ignored.
REQ-027 All outputs SHALL be registered; data_oe SHALL change no later than 4 CLOCK_50 cycles after a pin clock falling edge.

Reset
REQ-028 While resetn is 0 at posedge: state IDLE, ps2_clk_oe 0, ps2_data_oe 0, tx_ready 0, tx_done 0, tx_error 0, err_code 00, counters 0; tx_ready 1 from the first cycle after reset deasserts.
REQ-029 Reset mid-transfer SHALL release both lines at the next posedge and SHALL produce no tx_done/tx_error pulse.

Verification (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200; device model clocks at 10 kHz equivalent, sampling on rising edge)
REQ-030 Send 0xED -> clk_oe high 20 cycles, start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; model ACKs -> one tx_done, no tx_error.
REQ-031 Send 0xF4 -> data bits 0,0,1,0,1,1,1,1, parity 0; tx_done pulse; tx_ready back to 1 the next cycle.
REQ-032 Send 0xFF, model leaves data high on clock 11 -> tx_error pulse, err_code 10, both oe 0.
REQ-033 Send 0xFF, model stops clocking after edge 4 -> tx_error 200 cycles after edge 4, err_code 01, lines released.
REQ-034 Assert resetn=0 during bit 5 of 0xED -> both oe 0 next posedge, no pulses; a new send of 0xED after reset completes with tx_done.
REQ-035 Pulse tx_valid with 0x00 during an ongoing 0xED transfer -> ignored; the wire carries 0xED only.
